// File: rtl/dual_pe_mem_arbiter.sv
// Two-PE arbiter in front of a dual-port data memory. Each PE gets its own
// memory port. Requests are serialized only when both PEs hit the same
// in-range word and at least one of them is a store. A toggling priority
// pointer takes turns on such conflicts. Responses are registered one cycle
// after acceptance and are held while the PE back-pressures.
module dual_pe_mem_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p1_req_valid,
    input  logic        p2_req_valid,
    output logic        p1_req_ready,
    output logic        p2_req_ready,
    input  logic        p1_req_we,
    input  logic        p2_req_we,
    input  logic [31:0] p1_req_addr,
    input  logic [31:0] p2_req_addr,
    input  logic [31:0] p1_req_wdata,
    input  logic [31:0] p2_req_wdata,
    output logic        p1_rsp_valid,
    output logic        p2_rsp_valid,
    input  logic        p1_rsp_ready,
    input  logic        p2_rsp_ready,
    output logic [31:0] p1_rsp_rdata,
    output logic [31:0] p2_rsp_rdata,
    output logic        p1_rsp_err,
    output logic        p2_rsp_err,
    output logic        mem_we1,
    output logic        mem_we2,
    output logic [31:0] mem_a1,
    output logic [31:0] mem_a2,
    output logic [31:0] mem_wd1,
    output logic [31:0] mem_wd2,
    input  logic [31:0] mem_rd1,
    input  logic [31:0] mem_rd2,
    output logic [15:0] conflict_cnt
);
    localparam int NPE = 2;

    // Per-PE views of the flat port list; index 0 is PE1, index 1 is PE2.
    logic [NPE-1:0]       req_v, req_we, rsp_rdy, in_rng, grant, rdy, acc, we;
    logic [NPE-1:0][31:0] req_addr, req_wd, rd, ma, mwd;

    logic [NPE-1:0]       rsp_valid_q, rsp_err_q;
    logic [NPE-1:0][31:0] rsp_rdata_q;

    logic        prio_q, prio_d;
    logic [15:0] cnt_q, cnt_d;
    logic        conflict, prio_acc;

    assign req_v    = {p2_req_valid, p1_req_valid};
    assign req_we   = {p2_req_we, p1_req_we};
    assign rsp_rdy  = {p2_rsp_ready, p1_rsp_ready};
    assign req_addr = {p2_req_addr, p1_req_addr};
    assign req_wd   = {p2_req_wdata, p1_req_wdata};
    assign rd       = {mem_rd2, mem_rd1};

    // Same-word hazard. Two loads to one word are harmless. Out-of-range
    // requests never touch memory, so they cannot collide.
    assign conflict = (&req_v) && (&in_rng) && (|req_we) &&
                      (req_addr[0][ADDR_W-1:0] == req_addr[1][ADDR_W-1:0]);

    assign grant[0] = ~conflict | ~prio_q;
    assign grant[1] = ~conflict |  prio_q;

    for (genvar g = 0; g < NPE; g++) begin : g_pe
        assign in_rng[g] = (req_addr[g][31:ADDR_W] == '0);
        // Accept only when granted and the response slot is free or draining.
        assign rdy[g]    = grant[g] & (~rsp_valid_q[g] | rsp_rdy[g]) & ~rst;
        assign acc[g]    = req_v[g] & rdy[g];
        assign we[g]     = acc[g] & req_we[g] & in_rng[g];
        assign ma[g]     = req_v[g] ? {{(32-ADDR_W){1'b0}}, req_addr[g][ADDR_W-1:0]} : '0;
        assign mwd[g]    = req_v[g] ? req_wd[g] : '0;

        // Response slot: a new acceptance overwrites; otherwise drain on ready.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rsp_valid_q[g] <= 1'b0;
                rsp_rdata_q[g] <= '0;
                rsp_err_q[g]   <= 1'b0;
            end else if (acc[g]) begin
                rsp_valid_q[g] <= 1'b1;
                rsp_rdata_q[g] <= (~req_we[g] & in_rng[g]) ? rd[g] : '0;
                rsp_err_q[g]   <= ~in_rng[g];
            end else if (rsp_rdy[g]) begin
                rsp_valid_q[g] <= 1'b0;
            end
        end
    end

    // A conflict is only resolved once the favoured PE is actually accepted.
    always_comb begin
        prio_acc = conflict & (prio_q ? acc[1] : acc[0]);
        prio_d   = prio_q ^ prio_acc;
        cnt_d    = cnt_q;
        if (prio_acc && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    // Priority pointer and saturating conflict counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            prio_q <= prio_d;
            cnt_q  <= cnt_d;
        end
    end

    assign p1_req_ready = rdy[0];
    assign p2_req_ready = rdy[1];
    assign mem_we1      = we[0];
    assign mem_we2      = we[1];
    assign mem_a1       = ma[0];
    assign mem_a2       = ma[1];
    assign mem_wd1      = mwd[0];
    assign mem_wd2      = mwd[1];
    assign p1_rsp_valid = rsp_valid_q[0];
    assign p2_rsp_valid = rsp_valid_q[1];
    assign p1_rsp_rdata = rsp_rdata_q[0];
    assign p2_rsp_rdata = rsp_rdata_q[1];
    assign p1_rsp_err   = rsp_err_q[0];
    assign p2_rsp_err   = rsp_err_q[1];
    assign conflict_cnt = cnt_q;
endmodule

// File: doc/dual_pe_mem_arbiter.md
DUAL_PE_MEM_ARBITER -- requirements
Module: dual_pe_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the word-address width of the dual-port data memory (1024 words).
REQ-002 SHALL have ports, clock and reset first:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- p1_req_valid, p2_req_valid  input  1  PE request valid.
- p1_req_ready, p2_req_ready  output  1  request accepted this cycle when valid&ready.
- p1_req_we, p2_req_we  input  1  1=store, 0=load.
- p1_req_addr, p2_req_addr  input  32  word address.
- p1_req_wdata, p2_req_wdata  input  32  store data.
- p1_rsp_valid, p2_rsp_valid  output  1  response valid.
- p1_rsp_ready, p2_rsp_ready  input  1  PE accepts response.
- p1_rsp_rdata, p2_rsp_rdata  output  32  load data (0 for stores and errors).
- p1_rsp_err, p2_rsp_err  output  1  address out of range.
- mem_we1, mem_we2  output  1  memory write enables.
- mem_a1, mem_a2  output  32  memory addresses.
- mem_wd1, mem_wd2  output  32  memory write data.
- mem_rd1, mem_rd2  input  32  combinational memory read data.
- conflict_cnt  output  16  saturating count of serialized conflicts.

Function
REQ-003 SHALL treat PE n's request as in range when req_addr[31:ADDR_W]==0; otherwise it is an error request.
REQ-004 SHALL flag a conflict when both req_valid are high, both requests are in range, addr[ADDR_W-1:0] are equal, and at least one is a store; two loads to the same address SHALL NOT conflict.
REQ-005 SHALL grant both PEs when there is no conflict, and only the PE named by the 1-bit priority pointer `prio` (0=PE1, 1=PE2) when there is a conflict.
REQ-006 SHALL drive pN_req_ready = grantN & (~pN_rsp_valid | pN_rsp_ready) & ~rst.
- Readiness is combinational.
- A requester SHALL hold valid and payload stable until accepted.
REQ-007 SHALL toggle `prio` on every cycle in which a conflict exists and the prioritized PE's request is accepted; otherwise `prio` SHALL hold.
REQ-008 SHALL increment conflict_cnt by 1 on each such cycle, saturating at 16'hFFFF.
REQ-009 SHALL drive mem_aN = {zeros, pN_req_addr[ADDR_W-1:0]} and mem_wdN = pN_req_wdata whenever pN_req_valid is high, and 0 otherwise.
REQ-010 SHALL assert mem_weN only in the cycle PE n's in-range store is accepted; error stores SHALL never write.
REQ-011 SHALL, on acceptance, register the response at the next rising edge: pN_rsp_valid=1.
- pN_rsp_rdata = mem_rdN for an in-range load, else 0.
- pN_rsp_err = 1 for an error request.
- Load-to-response latency is exactly 1 cycle.
REQ-012 SHALL hold a response stable while pN_rsp_valid & ~pN_rsp_ready.
- pN_rsp_valid SHALL clear on pN_rsp_ready unless a new request is accepted in the same cycle, which overwrites the response (back-to-back throughput 1/cycle/PE).
REQ-013 SHALL keep the two PE response paths independent: a stalled response on one PE SHALL NOT block the other PE's non-conflicting requests.
REQ-014 SHALL return, for a load accepted in the same cycle as the other PE's store to a different address, the pre-store memory contents.

Reset
REQ-015 SHALL, while rst=1, asynchronously force the following and hold them until the first rising clk after rst falls:
- p1/p2_rsp_valid=0, p1/p2_rsp_rdata=0, p1/p2_rsp_err=0.
- prio=0, conflict_cnt=0.
- p1/p2_req_ready=0, mem_we1/mem_we2=0.
REQ-016 SHALL discard any response pending when rst asserts mid-operation; no request presented during reset SHALL be accepted or written.

Verification
REQ-017 Load, no conflict: PE1 loads addr 5 (mem=0xA5), PE2 loads addr 9 (mem=0x99), same cycle -> both ready=1; next cycle p1_rsp_rdata=0xA5, p2_rsp_rdata=0x99, err=0.
REQ-018 Store/store conflict: both PEs store addr 40 (PE1 data 0x1, PE2 data 0x2), prio=0:
- Cycle 0: only p1_req_ready=1, mem_we1=1.
- Cycle 1: p2 accepted, mem_we2=1.
- Final mem[40]=0x2; conflict_cnt=1, prio=1.
REQ-019 Load/load same address 7: both accepted same cycle, identical rdata, conflict_cnt unchanged.
REQ-020 Out of range: PE2 stores addr 0x400 -> accepted, mem_we2 stays 0, next cycle p2_rsp_err=1, p2_rsp_rdata=0.
REQ-021 Backpressure: p1_rsp_ready=0 with a pending response:
- p1_req_ready=0 and the response is held.
- PE2 continues at 1 request/cycle.
- Raising p1_rsp_ready re-enables p1_req_ready in the same cycle.
REQ-022 Reset mid-operation: assert rst with both responses valid -> rsp_valid=0, conflict_cnt=0, prio=0 immediately (asynchronously); no mem_we pulse until the first edge after release.
